// File: rtl/rf_wb_if.sv
// Writeback bus between the pipeline/multi-cycle unit (master) and the
// register-file writeback arbiter (slave).
interface rf_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   a_valid;
    logic [ADDR_W-1:0]      a_addr;
    logic [DATA_W-1:0]      a_data;
    logic                   b_valid;
    logic [ADDR_W-1:0]      b_addr;
    logic [DATA_W-1:0]      b_data;
    logic                   b_ready;
    logic                   regwrite;
    logic [ADDR_W-1:0]      writereg_addr;
    logic [DATA_W-1:0]      writedata;
    logic                   wb_src;
    logic [2**ADDR_W-1:0]   busy_vec;
    logic                   stall_req;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  b_ready, regwrite, writereg_addr, writedata, wb_src, busy_vec, stall_req
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output b_ready, regwrite, writereg_addr, writedata, wb_src, busy_vec, stall_req
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: pipeline source A has priority over a FIFO of source-B writes.
// Define RF_WB_BYPASS_EN to write a B transfer in its own cycle when A is idle and the FIFO is empty.
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int Q_DEPTH    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic   clk,
    input  logic   rst,
    rf_wb_if.slave bus
);
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_LIM + 1);
    localparam int NREG  = 2 ** ADDR_W;

    logic [ADDR_W-1:0] mem_addr_q [Q_DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [Q_DEPTH];
    logic [DATA_W-1:0] mem_data_q [Q_DEPTH];
    logic [DATA_W-1:0] mem_data_d [Q_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic              stall_q, stall_d;

    logic              a_act, q_empty, q_full, b_rdy, b_live, byp, push, pop;
    logic [PTR_W-1:0]  off;
    logic [NREG-1:0]   busy;

    // Request qualification: x0 targets count as idle (A) or as a discard (B).
    always_comb begin
        a_act   = bus.a_valid && (bus.a_addr != '0);
        q_empty = (count_q == '0);
        q_full  = (count_q == CNT_W'(Q_DEPTH));
        b_rdy   = !rst && !q_full;
        b_live  = bus.b_valid && b_rdy && (bus.b_addr != '0);
`ifdef RF_WB_BYPASS_EN
        byp     = b_live && !a_act && q_empty;
`else
        byp     = 1'b0;
`endif
        push    = b_live && !byp;
        pop     = !rst && !a_act && !q_empty;
    end

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (push) begin
            mem_addr_d[wptr_q] = bus.b_addr;
            mem_data_d[wptr_q] = bus.b_data;
            wptr_d             = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Age measures how long the current head has been blocked by A.
        if (pop || q_empty) begin
            age_d = '0;
        end else if (age_q == AGE_W'(STARVE_LIM)) begin
            age_d = age_q;
        end else begin
            age_d = age_q + AGE_W'(1);
        end

        // The head cannot change without a pop, so any pop while stalled retires the starved head.
        stall_d = stall_q;
        if (pop) begin
            stall_d = 1'b0;
        end else if (age_d == AGE_W'(STARVE_LIM)) begin
            stall_d = 1'b1;
        end

        if (rst) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            age_d   = '0;
            stall_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        wptr_q     <= wptr_d;
        rptr_q     <= rptr_d;
        count_q    <= count_d;
        age_q      <= age_d;
        stall_q    <= stall_d;
        mem_addr_q <= mem_addr_d;
        mem_data_q <= mem_data_d;
    end

    // Busy bits come only from slots between read pointer and read pointer + count.
    always_comb begin
        busy = '0;
        off  = '0;
        for (int i = 0; i < Q_DEPTH; i++) begin
            off = PTR_W'(i) - rptr_q;
            if ({1'b0, off} < count_q) begin
                busy[mem_addr_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        bus.regwrite      = 1'b0;
        bus.writereg_addr = '0;
        bus.writedata     = '0;
        bus.wb_src        = 1'b0;
        if (rst) begin
            bus.regwrite = 1'b0;
        end else if (a_act) begin
            bus.regwrite      = 1'b1;
            bus.writereg_addr = bus.a_addr;
            bus.writedata     = bus.a_data;
        end else if (!q_empty) begin
            bus.regwrite      = 1'b1;
            bus.writereg_addr = mem_addr_q[rptr_q];
            bus.writedata     = mem_data_q[rptr_q];
            bus.wb_src        = 1'b1;
        end else if (byp) begin
            bus.regwrite      = 1'b1;
            bus.writereg_addr = bus.b_addr;
            bus.writedata     = bus.b_data;
            bus.wb_src        = 1'b1;
        end
        bus.b_ready   = b_rdy;
        bus.busy_vec  = rst ? '0 : busy;
        bus.stall_req = stall_q;
    end
endmodule
